// File: rtl/cam_pkg.sv
// Shared DVP capture types and default geometry.
// The downstream sync generator uses these too.
package cam_pkg;

  typedef enum logic [1:0] {
    SKIP    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } cam_state_e;

  localparam int unsigned H_ACT_DEF       = 1280;
  localparam int unsigned V_ACT_DEF       = 720;
  localparam int unsigned SKIP_FRAMES_DEF = 10;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PIX_W  = 16;

  // Counter width with headroom above the nominal count so overruns are visible.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 2);
  endfunction

endpackage

// File: rtl/sig_edge.sv
// One-bit delay register with rise/fall detection of the input against
// its registered copy.
module sig_edge (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign q_o      = d_q;
  assign rise_c_o = d_i & ~d_q;
  assign fall_c_o = ~d_i & d_q;

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP camera capture: packs RGB565 byte pairs into pixels, skips warm-up
// frames after reset and checks line/frame geometry.
module cam_dvp_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACT       = H_ACT_DEF,
  parameter int unsigned V_ACT       = V_ACT_DEF,
  parameter int unsigned SKIP_FRAMES = SKIP_FRAMES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [BYTE_W-1:0] cam_data,
  input  logic              cam_href,
  input  logic              cam_vsync,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_href,
  output logic              pix_vsync,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              line_err
);

  localparam int unsigned PW = cnt_width(H_ACT);
  localparam int unsigned LW = cnt_width(V_ACT);
  localparam int unsigned SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [SW-1:0] SKIP_LAST = SW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam logic [PW-1:0] H_EXP     = PW'(H_ACT);
  localparam logic [LW-1:0] V_EXP     = LW'(V_ACT);
  localparam cam_state_e    RST_STATE = (SKIP_FRAMES > 0) ? SKIP : WAIT_VS;

  // Input stage S1: every camera signal is registered once before use
  logic [BYTE_W-1:0] data_s1_q;
  logic              href_s1_q;
  logic              vs_s1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_s1_q <= '0;
      href_s1_q <= 1'b0;
      vs_s1_q   <= 1'b0;
    end else begin
      data_s1_q <= cam_data;
      href_s1_q <= cam_href;
      vs_s1_q   <= cam_vsync;
    end
  end

  logic href_s2, href_fall, href_rise_unused;
  logic vs_s2, vs_rise, vs_fall_unused;

  sig_edge u_href_edge (
    .clk      (clk),
    .rstn     (rstn),
    .d_i      (href_s1_q),
    .q_o      (href_s2),
    .rise_c_o (href_rise_unused),
    .fall_c_o (href_fall)
  );

  sig_edge u_vs_edge (
    .clk      (clk),
    .rstn     (rstn),
    .d_i      (vs_s1_q),
    .q_o      (vs_s2),
    .rise_c_o (vs_rise),
    .fall_c_o (vs_fall_unused)
  );

  assign pix_href  = href_s2;
  assign pix_vsync = vs_s2;

  cam_state_e          state_q;
  logic [SW-1:0]       skip_cnt_q;
  logic [PW-1:0]       pix_cnt_q;
  logic [LW-1:0]       line_cnt_q;
  logic                phase_q;
  logic                frame_err_q;
  logic [BYTE_W-1:0]   hi_byte_q;
  logic [PIX_W-1:0]    pix_data_q;
  logic                pix_valid_q;
  logic                frame_start_q;
  logic                frame_done_q;
  logic                frame_ok_q;
  logic                line_err_q;

  // Frame FSM, counters and registered outputs; vsync handling has priority
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= RST_STATE;
      skip_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      phase_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      hi_byte_q     <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      unique case (state_q)
        SKIP: begin
          if (vs_rise) begin
            skip_cnt_q <= skip_cnt_q + SW'(1);
            if (skip_cnt_q == SKIP_LAST) begin
              state_q       <= ACTIVE;
              frame_start_q <= 1'b1;
            end
          end
        end
        WAIT_VS: begin
          if (vs_rise) begin
            state_q       <= ACTIVE;
            frame_start_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            frame_done_q  <= 1'b1;
            frame_start_q <= 1'b1;
            frame_ok_q    <= (line_cnt_q == V_EXP) && !frame_err_q;
            line_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            phase_q       <= 1'b0;
            frame_err_q   <= 1'b0;
          end else if (href_fall) begin
            line_cnt_q <= (&line_cnt_q) ? line_cnt_q : line_cnt_q + LW'(1);
            if ((pix_cnt_q != H_EXP) || phase_q) begin
              line_err_q  <= 1'b1;
              frame_err_q <= 1'b1;
            end
            pix_cnt_q <= '0;
            phase_q   <= 1'b0;
          end else if (href_s1_q) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              hi_byte_q <= data_s1_q;
            end else begin
              pix_data_q  <= {hi_byte_q, data_s1_q};
              pix_valid_q <= 1'b1;
              pix_cnt_q   <= (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + PW'(1);
            end
          end
        end
        default: state_q <= RST_STATE;
      endcase
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Self-checking bench for cam_dvp_capture with a small geometry
// (4 pixels x 3 lines, 2 skipped frames).
module tb_cam_dvp_capture;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned SK = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        cam_href = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_href, pix_vsync, frame_start, frame_done, frame_ok, line_err;

  always #5 clk = ~clk;

  cam_dvp_capture #(.H_ACT(H), .V_ACT(V), .SKIP_FRAMES(SK)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cam_data    (cam_data),
    .cam_href    (cam_href),
    .cam_vsync   (cam_vsync),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_href    (pix_href),
    .pix_vsync   (pix_vsync),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .line_err    (line_err)
  );

  int tests = 0;
  int fails = 0;

  // Event recorder fed from the DUT outputs
  int          pv_cnt = 0, lerr_cnt = 0, fs_cnt = 0, fd_cnt = 0, align_err = 0;
  logic        last_ok = 1'b0;
  logic [15:0] got_pix[$];
  logic [15:0] exp_pix[$];
  logic        h1 = 1'b0, h2 = 1'b0, v1 = 1'b0, v2 = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      h1 = 1'b0; h2 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    end else begin
      if (pix_valid) begin
        pv_cnt++;
        got_pix.push_back(pix_data);
      end
      if (line_err) lerr_cnt++;
      if (frame_start) fs_cnt++;
      if (frame_done) begin
        fd_cnt++;
        last_ok = frame_ok;
      end
      if (pix_href !== h2 || pix_vsync !== v2) align_err++;
      h2 = h1; h1 = cam_href;
      v2 = v1; v1 = cam_vsync;
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic [7:0] d);
    @(posedge clk); #1;
    cam_href = h; cam_vsync = v; cam_data = d;
  endtask

  // One line of n random bytes; optionally record the pixels it should yield
  task automatic send_line(input int n, input bit mdl);
    logic [7:0] b[$];
    for (int i = 0; i < n; i++) begin
      b.push_back(8'($urandom));
      drive(1'b1, 1'b0, b[i]);
    end
    if (mdl)
      for (int k = 0; k < n / 2; k++) exp_pix.push_back({b[2*k], b[2*k+1]});
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_frame(input int nl, input int len[4], input bit exp_ok,
                           input int exp_err, input bit mdl, input string nm);
    int le0, fd0;
    le0 = lerr_cnt;
    fd0 = fd_cnt;
    for (int l = 0; l < nl; l++) send_line(len[l], mdl);
    vs_pulse();
    check({nm, "_done"}, 32'(fd_cnt - fd0), 32'd1);
    check({nm, "_ok"}, 32'(last_ok), 32'(exp_ok));
    check({nm, "_lerr"}, 32'(lerr_cnt - le0), 32'(exp_err));
  endtask

  typedef struct {
    int nl;
    int len[4];
    bit ok;
    int err;
  } fvec_t;

  fvec_t vecs[8];

  initial begin
    int pv0, le0, fd0, nmis;
    int lens[4];

    vecs[0] = '{3, '{8, 8, 8, 0}, 1'b1, 0};
    vecs[1] = '{3, '{8, 7, 8, 0}, 1'b0, 1};
    vecs[2] = '{2, '{8, 8, 0, 0}, 1'b0, 0};
    vecs[3] = '{4, '{8, 8, 8, 8}, 1'b0, 0};
    vecs[4] = '{3, '{8, 10, 8, 0}, 1'b0, 1};
    vecs[5] = '{3, '{6, 6, 6, 0}, 1'b0, 3};
    vecs[6] = '{3, '{8, 8, 9, 0}, 1'b0, 1};
    vecs[7] = '{3, '{8, 8, 8, 0}, 1'b1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'({pix_valid, pix_data, pix_href, pix_vsync, frame_start,
                             frame_done, frame_ok, line_err}), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    rstn = 1'b1;

    // Warm-up: first frame has no leading vsync, second vsync opens capture
    pv0 = pv_cnt;
    for (int l = 0; l < 3; l++) send_line(8, 1'b0);
    vs_pulse();
    check("skip_fs_after_vs1", 32'(fs_cnt), 32'd0);
    for (int l = 0; l < 3; l++) send_line(8, 1'b0);
    check("skip_no_pix", 32'(pv_cnt - pv0), 32'd0);
    vs_pulse();
    check("skip_fs_after_vs2", 32'(fs_cnt), 32'd1);
    check("skip_no_done", 32'(fd_cnt), 32'd0);
    run_frame(3, '{8, 8, 8, 0}, 1'b1, 0, 1'b0, "good_frame");
    check("frame3_pix", 32'(pv_cnt - pv0), 32'd12);

    // Byte packing latency and line_err timing on a 2-byte line
    drive(1'b1, 1'b0, 8'h12);
    drive(1'b1, 1'b0, 8'h34);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("pack_not_yet", 32'(pix_valid), 32'd0);
    @(negedge clk);
    check("pack_valid", 32'(pix_valid), 32'd1);
    check("pack_data", 32'(pix_data), 32'h1234);
    check("pack_href_aligned", 32'(pix_href), 32'd1);
    check("short_lerr_early", 32'(line_err), 32'd0);
    @(negedge clk);
    check("short_lerr_pulse", 32'(line_err), 32'd1);
    check("short_pix_done", 32'(pix_valid), 32'd0);
    @(negedge clk);
    check("short_lerr_1cyc", 32'(line_err), 32'd0);
    fd0 = fd_cnt;
    vs_pulse();
    check("short_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("short_frame_ok", 32'(last_ok), 32'd0);

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].nl, vecs[i].len, vecs[i].ok, vecs[i].err, 1'b0,
                $sformatf("vec%0d", i));

    // href fall coincident with vsync rise: that line is neither counted nor checked
    le0 = lerr_cnt;
    fd0 = fd_cnt;
    send_line(8, 1'b0);
    send_line(8, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom));
    vs_pulse();
    check("coinc_done", 32'(fd_cnt - fd0), 32'd1);
    check("coinc_ok_2lines", 32'(last_ok), 32'd0);
    check("coinc_no_lerr", 32'(lerr_cnt - le0), 32'd0);
    le0 = lerr_cnt;
    for (int l = 0; l < 3; l++) send_line(8, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'($urandom));
    vs_pulse();
    check("coinc_short_ok", 32'(last_ok), 32'd1);
    check("coinc_short_lerr", 32'(lerr_cnt - le0), 32'd0);
    run_frame(3, '{8, 8, 8, 0}, 1'b1, 0, 1'b0, "after_coinc");

    // Random frames against the geometry/pixel model
    got_pix.delete();
    exp_pix.delete();
    for (int f = 0; f < 16; f++) begin
      int nl, nerr;
      bit ok;
      nl = int'($urandom_range(4, 2));
      nerr = 0;
      for (int l = 0; l < 4; l++) begin
        int r;
        r = int'($urandom_range(5, 0));
        lens[l] = (r < 4) ? 8 : (r == 4) ? 7 : int'($urandom_range(10, 2));
        if (l < nl && lens[l] != 8) nerr++;
      end
      ok = (nl == 3) && (nerr == 0);
      run_frame(nl, lens, ok, nerr, 1'b1, $sformatf("rand%0d", f));
    end
    check("rand_pix_count", 32'(got_pix.size()), 32'(exp_pix.size()));
    nmis = 0;
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++)
      if (got_pix[i] !== exp_pix[i]) nmis++;
    check("rand_pix_data", 32'(nmis), 32'd0);

    // Reset in the middle of a line after a good frame
    run_frame(3, '{8, 8, 8, 0}, 1'b1, 0, 1'b0, "pre_reset");
    drive(1'b1, 1'b0, 8'hA5);
    drive(1'b1, 1'b0, 8'h5A);
    drive(1'b1, 1'b0, 8'hC3);
    @(negedge clk);
    check("pre_reset_href", 32'(pix_href), 32'd1);
    check("pre_reset_ok", 32'(frame_ok), 32'd1);
    #1;
    rstn = 1'b0;
    cam_href = 1'b0;
    #1;
    check("midline_reset_outs", 32'({pix_valid, pix_data, pix_href, pix_vsync, frame_start,
                                     frame_done, frame_ok, line_err}), 32'd0);
    repeat (3) @(posedge clk);
    drive(1'b0, 1'b0, 8'h00);
    rstn = 1'b1;
    pv0 = pv_cnt;
    send_line(8, 1'b0);
    vs_pulse();
    send_line(8, 1'b0);
    check("rst_skip_no_pix", 32'(pv_cnt - pv0), 32'd0);
    vs_pulse();
    send_line(8, 1'b0);
    check("rst_pix_after_vs2", 32'(pv_cnt - pv0), 32'd4);

    check("href_vsync_align", 32'(align_err), 32'd0);
    check("start_done_pairing", 32'(fs_cnt), 32'(fd_cnt + 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
